keypad_scanner: RTL and testbench

- Sequences column drive of the 4x4 active-low matrix keypad and samples the row lines.
- Assembles one 16-bit raw key snapshot per scan frame.
- Publishes the snapshot as keys_pressed, the input to the keypad debounce/jitter stage.
- Owns the column-drive resource; downstream logic only ever sees whole, consistent frames.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 38 +++
 rtl/keypad_scanner.sv | 233 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared sizes, scan FSM states and key-index helper for the keypad scanner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        PUBLISH = 2'd2
    } scan_state_t;

    typedef logic [KEY_W-1:0] key_vec_t;

    // Bit position of a key inside a frame: columns are contiguous groups of rows.
    function automatic int unsigned key_idx(input int unsigned col, input int unsigned row);
        return col * NUM_ROWS + row;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs, resets to all-ones (released lines).
// Latency: 2 cycles from input change to output.
// Backpressure: none; free-running.
module sync_2ff #(
    parameter int                WIDTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    // Shift the raw input through the two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops; reset value matches an idle (pulled-up) line.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives 4x4 active-low keypad columns one at a time and publishes whole raw key frames.
// Latency: SETTLE_CYCLES cycles per column, frame period 4*SETTLE_CYCLES+1; keys_pressed updates with scan_done.
// Backpressure: none; scan_en low aborts the current frame and releases all columns. Option: KEYPAD_GHOST_REJECT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scan_en,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] cols,
    output key_vec_t            keys_pressed,
    output logic                scan_done,
    output logic                ghost
);

    localparam int               CNT_W    = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam int               COL_W    = $clog2(NUM_COLS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    // Two synchronizer cycles plus one cycle of line settle is the minimum window.
    generate
        if (SETTLE_CYCLES < 3) begin : g_bad_settle
            $error("keypad_scanner: SETTLE_CYCLES must be at least 3");
        end
    endgenerate

    scan_state_t         state_q;
    scan_state_t         state_d;
    logic [COL_W-1:0]    col_q;
    logic [COL_W-1:0]    col_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    key_vec_t            shadow_q;
    key_vec_t            shadow_d;
    key_vec_t            keys_q;
    key_vec_t            keys_d;
    logic [NUM_COLS-1:0] cols_q;
    logic [NUM_COLS-1:0] cols_d;
    logic                scan_done_q;
    logic                scan_done_d;

    logic [NUM_ROWS-1:0] rows_sync;
    logic [NUM_ROWS-1:0] rs;
    logic                sample_now;
    logic                last_col;
    logic                frame_end;
    key_vec_t            frame;

    sync_2ff #(
        .WIDTH     (NUM_ROWS),
        .RESET_VAL ({NUM_ROWS{1'b1}})
    ) u_rows_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rows_sync)
    );

    // Rows are pulled up, so a pressed key reads as a low row line.
    assign rs         = ~rows_sync;
    assign sample_now = (state_q == DRIVE) && (cnt_q == CNT_LAST);
    assign last_col   = (col_q == COL_LAST);
    assign frame_end  = sample_now && last_col;

    // Candidate frame: shadow with the current column's slice replaced by this edge's sample.
    always_comb begin
        frame = shadow_q;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_q == COL_W'(c)) begin
                frame[key_idx(c, 0) +: NUM_ROWS] = rs;
            end
        end
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    logic ghost_q;
    logic ghost_d;
    logic frame_is_ghost;

    // A 2x2 rectangle of pressed keys is indistinguishable from three keys plus a sneak path.
    function automatic logic is_ghost(input key_vec_t f);
        logic hit;
        hit = 1'b0;
        for (int a = 0; a < NUM_COLS; a++) begin
            for (int b = a + 1; b < NUM_COLS; b++) begin
                if ($countones(f[key_idx(a, 0) +: NUM_ROWS] & f[key_idx(b, 0) +: NUM_ROWS]) >= 2) begin
                    hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    assign frame_is_ghost = is_ghost(frame);
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: scan_en low always wins and drops back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (scan_en) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (!scan_en) begin
                    state_d = IDLE;
                end else if (frame_end) begin
                    state_d = PUBLISH;
                end
            end
            PUBLISH: begin
                state_d = scan_en ? DRIVE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Column index, settle counter, shadow frame and published keys.
    always_comb begin
        col_d    = col_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        keys_d   = keys_q;
`ifdef KEYPAD_GHOST_REJECT_EN
        ghost_d  = 1'b0;
`endif
        unique case (state_q)
            DRIVE: begin
                if (!scan_en) begin
                    // Abort: the partial frame is discarded, never published.
                    col_d    = '0;
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (sample_now) begin
                    shadow_d = frame;
                    cnt_d    = '0;
                    if (!last_col) begin
                        col_d = col_q + COL_W'(1);
                    end else begin
                        col_d = '0;
`ifdef KEYPAD_GHOST_REJECT_EN
                        ghost_d = frame_is_ghost;
                        if (!frame_is_ghost) begin
                            keys_d = frame;
                        end
`else
                        keys_d = frame;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                col_d    = '0;
                cnt_d    = '0;
                shadow_d = '0;
            end
            default: begin
                col_d = '0;
                cnt_d = '0;
            end
        endcase
    end

    // FSM outputs, computed from the next state so the pins come straight off flops.
    always_comb begin
        cols_d      = '1;
        scan_done_d = 1'b0;
        if (state_d == DRIVE) begin
            cols_d = ~(NUM_COLS'(1) << col_d);
        end
        if (state_d == PUBLISH) begin
            scan_done_d = 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            keys_q      <= '0;
            cols_q      <= '1;
            scan_done_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            keys_q      <= keys_d;
            cols_q      <= cols_d;
            scan_done_q <= scan_done_d;
        end
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    // Ghost flag is high only for the publish cycle of a rejected frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghost_q <= 1'b0;
        end else begin
            ghost_q <= ghost_d;
        end
    end

    assign ghost = ghost_q;
`else
    assign ghost = 1'b0;
`endif

    assign cols         = cols_q;
    assign keys_pressed = keys_q;
    assign scan_done    = scan_done_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad frames checked against a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_scanner;

    localparam int S     = 4;
    localparam int FRAME = 4 * S + 1;
`ifdef KEYPAD_GHOST_REJECT_EN
    localparam bit GHOST_ON = 1'b1;
`else
    localparam bit GHOST_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_en;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [15:0] keys_pressed;
    logic        scan_done;
    logic        ghost;

    logic [15:0] kmat;        // physically pressed keys, bit = col*4+row
    logic [15:0] model_keys;  // what keys_pressed should currently show
    int          total = 0;
    int          bad   = 0;

    keypad_scanner #(.SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .scan_en      (scan_en),
        .rows         (rows),
        .cols         (cols),
        .keys_pressed (keys_pressed),
        .scan_done    (scan_done),
        .ghost        (ghost)
    );

    always #5 clk = ~clk;

    // Diode keypad: a row is pulled low only through a driven column with that key pressed.
    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!cols[c]) rows = rows & ~kmat[c*4 +: 4];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two distinct columns sharing at least two pressed rows.
    function automatic bit has_rect(input logic [15:0] f);
        for (int a = 0; a < 4; a++) begin
            for (int b = a + 1; b < 4; b++) begin
                int n;
                n = 0;
                for (int r = 0; r < 4; r++) begin
                    if (f[a*4 + r] && f[b*4 + r]) n++;
                end
                if (n >= 2) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // One full frame from the cycle before column 0 is driven; kmat held for the whole frame
    // except an optional one-cycle glitch early in column 1's window.
    task automatic run_frame(input logic [15:0] glitch);
        logic [15:0] cand;
        logic [15:0] base;
        logic        exp_ghost;
        logic [3:0]  exp_cols;
        cand      = kmat;
        base      = kmat;
        exp_ghost = GHOST_ON && has_rect(cand);
        for (int k = 1; k <= FRAME; k++) begin
            step();
            if (k == 5) kmat = base | glitch;
            if (k == 6) kmat = base;
            exp_cols = (k < FRAME) ? ~(4'b0001 << ((k - 1) / S)) : 4'hF;
            check("cols_seq", cols, exp_cols);
            check("scan_done_timing", scan_done, k == FRAME);
            if (k < FRAME) begin
                check("keys_hold", keys_pressed, model_keys);
                check("ghost_low", ghost, 1'b0);
            end
        end
        if (!exp_ghost) model_keys = cand;
        check("keys_frame", keys_pressed, model_keys);
        check("ghost_frame", ghost, exp_ghost);
    endtask

    // At most one column driven low at any time.
    always @(negedge clk) begin
        if (reset === 1'b0) check("cols_one_low", $countones(~cols) <= 1, 1'b1);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int j;
        int c1, c2, r1, r2;
        reset      = 1'b1;
        scan_en    = 1'b0;
        kmat       = 16'h0000;
        model_keys = 16'h0000;
        repeat (3) step();
        check("rst_cols", cols, 4'hF);
        check("rst_keys", keys_pressed, 16'h0000);
        check("rst_done", scan_done, 1'b0);
        check("rst_ghost", ghost, 1'b0);

        // No keys: two back-to-back frames give the column sequence and 17-cycle period.
        reset   = 1'b0;
        scan_en = 1'b1;
        run_frame(16'h0);
        run_frame(16'h0);
        check("t1_keys", keys_pressed, 16'h0000);

        // Single key col2/row1, then released.
        kmat = 16'h0200;
        run_frame(16'h0);
        check("t2_press", keys_pressed, 16'h0200);
        kmat = 16'h0000;
        run_frame(16'h0);
        check("t2_release", keys_pressed, 16'h0000);

        // Corner keys, with a short glitch in column 1 that must be ignored.
        kmat = 16'h8001;
        run_frame(16'h0040);
        check("t3_corners", keys_pressed, 16'h8001);

        // Abort at cycle 10 with col3/row0 held.
        kmat = 16'h1000;
        repeat (10) step();
        scan_en = 1'b0;
        step();
        check("t4_abort_cols", cols, 4'hF);
        check("t4_abort_done", scan_done, 1'b0);
        check("t4_abort_keys", keys_pressed, 16'h8001);
        repeat (3) begin
            step();
            check("t4_idle_done", scan_done, 1'b0);
            check("t4_idle_keys", keys_pressed, 16'h8001);
        end
        scan_en = 1'b1;
        run_frame(16'h0);
        check("t4_resume", keys_pressed, 16'h1000);

        // Reset while driving column 2.
        kmat = 16'h0200;
        run_frame(16'h0);
        repeat (9) step();
        check("t5_in_col2", cols, 4'b1011);
        reset = 1'b1;
        step();
        check("t5_rst_keys", keys_pressed, 16'h0000);
        check("t5_rst_cols", cols, 4'hF);
        check("t5_rst_done", scan_done, 1'b0);
        model_keys = 16'h0000;
        reset = 1'b0;
        run_frame(16'h0);
        check("t5_resume", keys_pressed, 16'h0200);

        // Rectangle frame: rejected with the option, published without it.
        kmat = 16'h0033;
        run_frame(16'h0);
        check("t6_keys", keys_pressed, GHOST_ON ? 16'h0200 : 16'h0033);
        check("t6_ghost", ghost, GHOST_ON);

        // Random frames, some with rectangles, glitches and aborts.
        repeat (40) begin
            kmat = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                c1 = $urandom_range(0, 3);
                c2 = (c1 + $urandom_range(1, 3)) % 4;
                r1 = $urandom_range(0, 3);
                r2 = (r1 + $urandom_range(1, 3)) % 4;
                kmat[c1*4 + r1] = 1'b1;
                kmat[c1*4 + r2] = 1'b1;
                kmat[c2*4 + r1] = 1'b1;
                kmat[c2*4 + r2] = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) begin
                j = $urandom_range(1, 16);
                repeat (j) step();
                scan_en = 1'b0;
                step();
                check("rnd_abort_cols", cols, 4'hF);
                check("rnd_abort_done", scan_done, 1'b0);
                check("rnd_abort_keys", keys_pressed, model_keys);
                j = $urandom_range(0, 3);
                repeat (j) step();
                scan_en = 1'b1;
            end
            run_frame(16'($urandom_range(0, 15)) << 4);
        end

        scan_en = 1'b0;
        step();
        step();
        check("end_cols", cols, 4'hF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
